// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for the two-requester memory port arbiter: both requester
// command ports, the downstream memory command port and the status outputs.
interface mem_port_arbiter_if;
    logic [27:0] rq0_data_addr;
    logic [31:0] rq0_data_wr;
    logic        rq0_rw;
    logic        rq0_valid;
    logic        rq0_ready;
    logic [31:0] rq0_data_rd;

    logic [27:0] rq1_data_addr;
    logic [31:0] rq1_data_wr;
    logic        rq1_rw;
    logic        rq1_valid;
    logic        rq1_ready;
    logic [31:0] rq1_data_rd;

    logic [27:0] mem_data_addr;
    logic [31:0] mem_data_wr;
    logic        mem_rw_data;
    logic        mem_valid_data;
    logic [31:0] mem_data_rd;
    logic        mem_ready_data;

    logic [1:0]  grant;
    logic        error;

    modport slave (
        input  rq0_data_addr, rq0_data_wr, rq0_rw, rq0_valid,
        output rq0_ready, rq0_data_rd,
        input  rq1_data_addr, rq1_data_wr, rq1_rw, rq1_valid,
        output rq1_ready, rq1_data_rd,
        output mem_data_addr, mem_data_wr, mem_rw_data, mem_valid_data,
        input  mem_data_rd, mem_ready_data,
        output grant, error
    );

    modport master (
        output rq0_data_addr, rq0_data_wr, rq0_rw, rq0_valid,
        input  rq0_ready, rq0_data_rd,
        output rq1_data_addr, rq1_data_wr, rq1_rw, rq1_valid,
        input  rq1_ready, rq1_data_rd,
        input  mem_data_addr, mem_data_wr, mem_rw_data, mem_valid_data,
        output mem_data_rd, mem_ready_data,
        input  grant, error
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory command port between two requesters,
// with a registered downstream command, winner-only response and a watchdog.
module mem_port_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned CNT_W          = 16
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Watchdog value seen during the TIMEOUT_CYCLES-th BUSY cycle (counter starts at 0)
    localparam logic [CNT_W-1:0] WD_LAST = (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] WD_MAX  = '1;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_last_grant;
    logic [1:0]        r_grant;
    logic              r_mem_valid;
    logic              r_mem_rw;
    logic [27:0]       r_mem_addr;
    logic [31:0]       r_mem_wr;
    logic              r_error;
    logic [CNT_W-1:0]  r_wd;

    logic              w_win;
    logic              w_pick1;
    logic              w_busy;
    logic              w_timeout;
    logic              w_done;

    assign w_win     = bus.rq0_valid | bus.rq1_valid;
    assign w_pick1   = bus.rq1_valid & (~bus.rq0_valid | ~r_last_grant);
    assign w_busy    = (r_state == S_BUSY);
    assign w_timeout = (TIMEOUT_CYCLES != 0) && w_busy && !bus.mem_ready_data && (r_wd == WD_LAST);
    assign w_done    = w_busy & (bus.mem_ready_data | w_timeout);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_win)  w_state_nxt = S_BUSY;
            S_BUSY:  if (w_done) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        bus.rq0_ready   = 1'b0;
        bus.rq1_ready   = 1'b0;
        bus.rq0_data_rd = '0;
        bus.rq1_data_rd = '0;
        if (w_done) begin
            bus.rq0_ready = r_grant[0];
            bus.rq1_ready = r_grant[1];
            // A timeout completion returns zero data
            if (bus.mem_ready_data) begin
                if (r_grant[0]) bus.rq0_data_rd = bus.mem_data_rd;
                if (r_grant[1]) bus.rq1_data_rd = bus.mem_data_rd;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last_grant <= 1'b1;
            r_grant      <= 2'b00;
            r_mem_valid  <= 1'b0;
            r_mem_rw     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wr     <= '0;
            r_error      <= 1'b0;
            r_wd         <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_win) begin
                        r_mem_addr  <= w_pick1 ? bus.rq1_data_addr : bus.rq0_data_addr;
                        r_mem_wr    <= w_pick1 ? bus.rq1_data_wr   : bus.rq0_data_wr;
                        r_mem_rw    <= w_pick1 ? bus.rq1_rw        : bus.rq0_rw;
                        r_mem_valid <= 1'b1;
                        r_grant     <= w_pick1 ? 2'b10 : 2'b01;
                        r_wd        <= '0;
                    end
                end
                S_BUSY: begin
                    if (w_done) begin
                        r_mem_valid  <= 1'b0;
                        r_mem_rw     <= 1'b0;
                        r_last_grant <= r_grant[1];
                        r_grant      <= 2'b00;
                        if (w_timeout) r_error <= 1'b1;
                    end else if (r_wd != WD_MAX) begin
                        r_wd <= r_wd + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.mem_data_addr  = r_mem_addr;
    assign bus.mem_data_wr    = r_mem_wr;
    assign bus.mem_rw_data    = r_mem_rw;
    assign bus.mem_valid_data = r_mem_valid;
    assign bus.grant          = r_grant;
    assign bus.error          = r_error;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: transaction-level requester/memory
// model with round-robin winner prediction and cycle checks of the port.
module tb_mem_port_arbiter;

    localparam int TMO = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    mem_port_arbiter_if bus();

    mem_port_arbiter #(.TIMEOUT_CYCLES(TMO), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_bad = 0;
    bit          pend   [2];
    logic [27:0] c_addr [2];
    logic [31:0] c_wr   [2];
    logic        c_rw   [2];
    int          last;
    bit          exp_err;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic rdy(input int n);
        return (n == 0) ? bus.rq0_ready : bus.rq1_ready;
    endfunction

    function automatic logic [31:0] rdat(input int n);
        return (n == 0) ? bus.rq0_data_rd : bus.rq1_data_rd;
    endfunction

    task automatic drive_rq(input int n, input logic [27:0] a, input logic [31:0] d, input logic rw);
        if (n == 0) begin
            bus.rq0_data_addr = a; bus.rq0_data_wr = d; bus.rq0_rw = rw;
        end else begin
            bus.rq1_data_addr = a; bus.rq1_data_wr = d; bus.rq1_rw = rw;
        end
    endtask

    task automatic set_valid(input int n, input logic v);
        if (n == 0) bus.rq0_valid = v;
        else        bus.rq1_valid = v;
    endtask

    task automatic raise(input int n, input logic [27:0] a, input logic [31:0] d, input logic rw);
        pend[n] = 1'b1; c_addr[n] = a; c_wr[n] = d; c_rw[n] = rw;
        drive_rq(n, a, d, rw);
        set_valid(n, 1'b1);
    endtask

    task automatic raise_rand(input int n);
        raise(n, 28'($urandom), $urandom, 1'($urandom));
    endtask

    task automatic apply_reset();
        @(negedge clk);
        set_valid(0, 1'b0); set_valid(1, 1'b0);
        drive_rq(0, '0, '0, 1'b0); drive_rq(1, '0, '0, 1'b0);
        bus.mem_ready_data = 1'b0; bus.mem_data_rd = '0;
        rst = 1'b0;
        #1;
        chk("rst_mem_valid", bus.mem_valid_data, 0);
        chk("rst_grant", bus.grant, 2'b00);
        chk("rst_error", bus.error, 0);
        chk("rst_mem_rw", bus.mem_rw_data, 0);
        chk("rst_mem_addr", bus.mem_data_addr, 0);
        chk("rst_mem_wr", bus.mem_data_wr, 0);
        repeat (2) @(negedge clk);
        // Requests during reset must not leak into the port
        raise(0, 28'h1234567, 32'hDEADBEEF, 1'b1);
        @(negedge clk);
        #1;
        chk("rst_hold_valid", bus.mem_valid_data, 0);
        chk("rst_hold_ready", rdy(0), 0);
        set_valid(0, 1'b0);
        pend[0] = 1'b0; pend[1] = 1'b0;
        last = 1; exp_err = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Entered at the negedge of an IDLE cycle with requester valids set up.
    // lat = BUSY cycles until memory responds; 0 = memory never responds.
    task automatic serve_one(input int lat, input bit sticky, input bit spur, input logic [31:0] rdata);
        int  w, o, n;
        bit  tmo;
        if (pend[0] && pend[1]) w = (last == 1) ? 0 : 1;
        else if (pend[0])       w = 0;
        else                    w = 1;
        o   = 1 - w;
        tmo = (lat == 0);
        n   = tmo ? TMO : lat;
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            if (c == n && !tmo) begin
                bus.mem_data_rd = rdata; bus.mem_ready_data = 1'b1;
            end else begin
                bus.mem_data_rd = $urandom; bus.mem_ready_data = 1'b0;
            end
            #1;
            chk("busy_valid", bus.mem_valid_data, 1);
            chk("busy_addr", bus.mem_data_addr, c_addr[w]);
            chk("busy_wr", bus.mem_data_wr, c_wr[w]);
            chk("busy_rw", bus.mem_rw_data, c_rw[w]);
            chk("busy_grant", bus.grant, (w == 0) ? 2'b01 : 2'b10);
            chk("busy_error", bus.error, exp_err);
            chk("other_ready", rdy(o), 0);
            chk("other_data", rdat(o), 0);
            chk("win_ready", rdy(w), (c == n) ? 1 : 0);
            if (c == n && (tmo || !c_rw[w])) chk("win_data", rdat(w), tmo ? 32'h0 : rdata);
            if (c == 1) drive_rq(w, 28'($urandom), $urandom, 1'($urandom));
            if (c == n && !sticky) set_valid(w, 1'b0);
        end
        pend[w] = 1'b0;
        last    = w;
        if (tmo) exp_err = 1'b1;
        @(negedge clk);
        bus.mem_ready_data = spur;
        bus.mem_data_rd    = $urandom;
        #1;
        chk("done_grant", bus.grant, 2'b00);
        chk("done_valid", bus.mem_valid_data, 0);
        chk("done_rw", bus.mem_rw_data, 0);
        chk("done_error", bus.error, exp_err);
        chk("done_ready0", bus.rq0_ready, 0);
        chk("done_ready1", bus.rq1_ready, 0);
        @(negedge clk);
        bus.mem_ready_data = 1'b0;
        if (sticky) set_valid(w, 1'b0);
        #1;
        chk("idle_grant", bus.grant, 2'b00);
        chk("idle_valid", bus.mem_valid_data, 0);
        chk("idle_error", bus.error, exp_err);
        chk("idle_ready", {bus.rq0_ready, bus.rq1_ready}, 2'b00);
    endtask

    task automatic rand_round(input bit allow_tmo);
        for (int n = 0; n < 2; n++)
            if (!pend[n] && $urandom_range(0, 1) == 1) raise_rand(n);
        if (!pend[0] && !pend[1]) raise_rand($urandom_range(0, 1));
        if (allow_tmo && $urandom_range(0, 9) == 0)
            serve_one(0, 1'($urandom), 1'($urandom), $urandom);
        else
            serve_one($urandom_range(1, TMO), 1'($urandom), 1'($urandom), $urandom);
    endtask

    initial begin
        bus.rq0_valid = 1'b0; bus.rq1_valid = 1'b0;
        drive_rq(0, '0, '0, 1'b0); drive_rq(1, '0, '0, 1'b0);
        bus.mem_ready_data = 1'b0; bus.mem_data_rd = '0;
        #2 rst = 1'b0;
        apply_reset();

        // Single read from rq0
        raise(0, 28'h000_0008, 32'h0, 1'b0);
        serve_one(3, 1'b0, 1'b0, 32'h010000FF);

        // Simultaneous requests from reset: rq0 write wins, then rq1 read
        apply_reset();
        raise(0, 28'h100_0008, 32'h000AAAAA, 1'b1);
        raise(1, 28'h230_0030, 32'h0, 1'b0);
        serve_one(2, 1'b0, 1'b0, $urandom);
        serve_one(4, 1'b0, 1'b0, $urandom);

        // Fairness: both keep requesting for 6 transactions
        raise_rand(0); raise_rand(1);
        for (int i = 0; i < 6; i++) begin
            serve_one($urandom_range(1, 5), 1'b0, 1'($urandom), $urandom);
            raise_rand(last);
        end
        serve_one(1, 1'b0, 1'b0, $urandom);
        serve_one(1, 1'b0, 1'b0, $urandom);

        // Sticky valid: no duplicate command afterwards
        raise(1, 28'h0000_040, 32'h5555AAAA, 1'b1);
        serve_one(2, 1'b1, 1'b0, $urandom);
        @(negedge clk); #1;
        chk("sticky_no_dup", bus.mem_valid_data, 0);
        chk("sticky_grant", bus.grant, 2'b00);

        // Response on the timeout cycle itself completes normally
        raise(0, 28'h0000_100, 32'h0, 1'b0);
        serve_one(TMO, 1'b0, 1'b0, 32'hCAFE0001);

        for (int i = 0; i < 60; i++) rand_round(1'b0);

        // Memory never responds
        raise(1, 28'h0ABC_000, 32'h0, 1'b0);
        serve_one(0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 60; i++) rand_round(1'b1);
        chk("error_sticky", bus.error, 1);

        // Asynchronous reset while a write is outstanding
        for (int n = 0; n < 2; n++) if (pend[n]) begin set_valid(n, 1'b0); pend[n] = 1'b0; end
        raise(1, 28'h0ABCDEF, 32'h12345678, 1'b1);
        @(negedge clk); #1;
        chk("mid_valid_pre", bus.mem_valid_data, 1);
        chk("mid_grant_pre", bus.grant, 2'b10);
        #2 rst = 1'b0;
        #1;
        chk("mid_valid", bus.mem_valid_data, 0);
        chk("mid_grant", bus.grant, 2'b00);
        chk("mid_error", bus.error, 0);
        chk("mid_addr", bus.mem_data_addr, 0);
        bus.mem_ready_data = 1'b1;
        #1;
        chk("mid_no_ready", {bus.rq0_ready, bus.rq1_ready}, 2'b00);
        @(negedge clk);
        bus.mem_ready_data = 1'b0;
        set_valid(1, 1'b0);
        pend[0] = 1'b0; pend[1] = 1'b0; last = 1; exp_err = 1'b0;
        rst = 1'b1;
        raise(1, 28'h0000_200, 32'h0, 1'b0);
        serve_one(3, 1'b0, 1'b0, 32'h0BADF00D);
        raise(0, 28'h0000_300, 32'h0, 1'b0);
        raise(1, 28'h0000_304, 32'h0, 1'b0);
        serve_one(2, 1'b0, 1'b0, $urandom);
        serve_one(2, 1'b0, 1'b0, $urandom);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Two-requester arbiter that shares the single cache-to-DDR2 memory command port between the instruction-side requester (rq0) and the data-side requester (rq1).
- Uses the same valid/ready/rw handshake as the cache memory interface.
- Captures the winning command into registers and holds it on the downstream port until the memory responds.
- Returns the response to the winner only, with round-robin fairness and a response watchdog.

Parameters:
- TIMEOUT_CYCLES, 1024: maximum BUSY cycles before abort. 0 disables the watchdog.
- CNT_W, 16: watchdog counter width. TIMEOUT_CYCLES must be less than 2^CNT_W.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-low reset (0 = reset)
- rqN_data_addr  input  28  command address from requester N (N = 0, 1)
- rqN_data_wr  input  32  write data from requester N
- rqN_rw  input  1  requester N command type: 1 = write, 0 = read
- rqN_valid  input  1  requester N command valid
- rqN_ready  output  1  one-cycle completion pulse to requester N
- rqN_data_rd  output  32  read data to requester N, valid while rqN_ready = 1
- mem_data_addr  output  28  registered address to memory
- mem_data_wr  output  32  registered write data to memory
- mem_rw_data  output  1  registered command type to memory
- mem_valid_data  output  1  command valid to memory
- mem_data_rd  input  32  read data from memory
- mem_ready_data  input  1  memory completion pulse
- grant  output  2  one-hot owner of the port, 00 when idle
- error  output  1  sticky watchdog-timeout flag

Behaviour:
- Reset (rst = 0, asynchronous):
  - state = IDLE; last_grant = 1, so rq0 wins the first tie.
  - grant = 00; mem_valid_data = 0; mem_rw_data = 0.
  - mem_data_addr = 0; mem_data_wr = 0; error = 0; watchdog = 0.
  - rqN_ready = 0.
  - Reset asserted mid-transaction abandons the command; no ready pulse is generated.
- State machine, three states:
  - IDLE:
    - Sample rq0_valid and rq1_valid.
    - If only one is valid, that requester wins.
    - If both are valid, the requester that is not last_grant wins (round robin).
    - On a win: latch the winner's addr, wr and rw into the mem_* registers; set mem_valid_data = 1; set grant; clear the watchdog; go to BUSY. All take effect at the next edge, so there is one cycle of latency from request to mem_valid_data.
  - BUSY:
    - mem_valid_data and all mem_* outputs are held stable.
    - Requester inputs are ignored, including changes by the winner.
    - When mem_ready_data = 1:
      - rqW_ready = mem_ready_data combinationally, in the same cycle.
      - rqW_data_rd = mem_data_rd, passed through for reads; for writes the value is don't-care.
      - Next edge: mem_valid_data = 0, mem_rw_data = 0, last_grant = W, go to DONE.
    - Watchdog counts BUSY cycles. If TIMEOUT_CYCLES != 0 and the count reaches TIMEOUT_CYCLES with no mem_ready_data:
      - error is set and stays set until reset.
      - rqW_ready pulses for that cycle with rqW_data_rd = 0.
      - The machine then proceeds as for a normal completion.
    - If mem_ready_data arrives in the same cycle as the timeout, the ready takes priority: completion is normal and error is not set.
  - DONE, one cycle:
    - grant = 00.
    - The just-served requester's valid is ignored this cycle. This absorbs requesters that drop valid one cycle after ready.
    - Go to IDLE.
    - Minimum spacing between two downstream commands is 3 cycles from ready to the next mem_valid_data.
- rqN_ready is never asserted for the non-granted requester.
- rqN_data_rd of the non-granted requester is driven 0.
- mem_ready_data seen in IDLE or DONE is ignored and is not an error.
- Width rules:
  - Address, data and rw are passed unchanged; there is no arithmetic on the datapath.
  - The watchdog saturates at 2^CNT_W - 1 and does not wrap.

Test Plan:
- Single read: rq0 read at addr 28'h000_0008; memory returns ready after 3 cycles with data 32'h010000FF.
  - Required: mem_valid_data = 1 at the cycle after request, addr 28'h000_0008, rw = 0.
  - Required: rq0_ready is a single pulse carrying 32'h010000FF; rq1_ready stays 0.
- Simultaneous requests: rq0 write (addr 28'h100_0008, data 32'h000AAAAA) and rq1 read (addr 28'h230_0030) raised in the same cycle from reset.
  - Required: rq0 is served first, then rq1 starts 3 cycles after rq0's ready.
  - Required: grant sequence 01, 00, 10.
- Fairness: both requesters hold valid continuously for 6 transactions.
  - Required: grants alternate 01/10 exactly, 3 each.
- Sticky valid: requester keeps valid high one cycle past ready, then drops it.
  - Required: exactly one downstream command is issued; no duplicate.
- Timeout: TIMEOUT_CYCLES = 8 and memory never responds.
  - Required: after 8 BUSY cycles, error = 1, rqW_ready pulses with data 0, state returns to IDLE.
  - Required: error remains 1 after later good transactions.
- Reset mid-BUSY: assert rst = 0 asynchronously between clock edges while a write is outstanding.
  - Required: mem_valid_data, grant and error go to 0 immediately.
  - Required: no ready pulse is generated; a new request after release is served normally.
